// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: state encodings, stack entry
// layout, default vector placement and the vector address helper.
package interrupt_sequencer_pkg;

  localparam int IRQ_ID_W = 4;
  localparam int PC_W     = 16;
  localparam int ENTRY_W  = PC_W + IRQ_ID_W + 1;

  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0010;
  localparam logic [15:0] DEF_VECTOR_STRIDE = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_RETURN   = 2'd2,
    ST_SETTLE   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [IRQ_ID_W-1:0] id;
    logic                ie;
  } stack_entry_t;

  // Vector table lives at base + id*stride; the sum wraps at 16 bits.
  function automatic logic [15:0] vector_addr(input logic [15:0]         base,
                                              input logic [15:0]         stride,
                                              input logic [IRQ_ID_W-1:0] id);
    return base + (stride * {12'd0, id});
  endfunction

endpackage

// File: rtl/interrupt_sequencer_stack.sv
// sequencer_stack: small LIFO holding the interrupt return context.
// Reset discards the contents by clearing the count; storage is not reset.
module sequencer_stack
  import interrupt_sequencer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] top,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      top_ptr;

  // With a power-of-two depth the low bits of the count address the next slot.
  assign wr_ptr  = cnt_q[AW-1:0];
  assign top_ptr = wr_ptr - AW'(1);
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign top     = empty ? '0 : mem[top_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: takes pending interrupts at instruction boundaries,
// stacks the return context, redirects fetch and clears on return.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | CPU running; reti / take / ie_set / ie_clr evaluated here
// REDIRECT | context pushed; fetch redirected to the vector of top entry
// RETURN   | context popped; fetch redirected to saved pc, clear pulse
// SETTLE   | one quiet cycle so the controller's outputs can update
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter  int          DEPTH         = 4,
  parameter  logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter  logic [15:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE,
  localparam int          DW            = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_interrupt,
  input  logic [IRQ_ID_W-1:0] cpu_interrupt_id,
  input  logic                instr_boundary,
  input  logic [PC_W-1:0]     pc,
  input  logic                reti,
  input  logic                ie_set,
  input  logic                ie_clr,
  output logic                handle_interrupt,
  output logic                clear_interrupt,
  output logic [IRQ_ID_W-1:0] clear_interrupt_id,
  output logic                stall,
  output logic                redirect,
  output logic [PC_W-1:0]     redirect_pc,
  output logic [DW-1:0]       depth,
  output logic                underflow
);

  seq_state_t          state_q, state_d;
  logic                ie_q, ie_d;
  logic                underflow_q, underflow_d;
  logic [PC_W-1:0]     ret_pc_q, ret_pc_d;
  logic [IRQ_ID_W-1:0] ret_id_q, ret_id_d;

  logic                push, pop;
  logic                full, empty;
  logic [ENTRY_W-1:0]  top_raw;
  stack_entry_t        top_e;
  stack_entry_t        push_e;
  logic                take;

  assign top_e  = stack_entry_t'(top_raw);
  assign push_e = '{pc: pc, id: cpu_interrupt_id, ie: ie_q};

  sequencer_stack #(.DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (push_e),
    .top       (top_raw),
    .full      (full),
    .empty     (empty),
    .count     (depth)
  );

  // Re-taking the interrupt already being serviced would nest it on itself.
  assign take = instr_boundary && cpu_interrupt && ie_q && !full &&
                (empty || (cpu_interrupt_id != top_e.id));

  assign handle_interrupt = ie_q && !full;
  assign underflow        = underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ie_q        <= 1'b0;
      underflow_q <= 1'b0;
      ret_pc_q    <= '0;
      ret_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ie_q        <= ie_d;
      underflow_q <= underflow_d;
      ret_pc_q    <= ret_pc_d;
      ret_id_q    <= ret_id_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    ie_d               = ie_q;
    underflow_d        = underflow_q;
    ret_pc_d           = ret_pc_q;
    ret_id_d           = ret_id_q;
    push               = 1'b0;
    pop                = 1'b0;
    stall              = 1'b1;
    redirect           = 1'b0;
    redirect_pc        = '0;
    clear_interrupt    = 1'b0;
    clear_interrupt_id = '0;

    unique case (state_q)
      ST_IDLE: begin
        stall = 1'b0;
        if (reti && instr_boundary) begin
          if (!empty) begin
            pop      = 1'b1;
            ret_pc_d = top_e.pc;
            ret_id_d = top_e.id;
            ie_d     = top_e.ie;
            state_d  = ST_RETURN;
          end else begin
            underflow_d = 1'b1;
          end
        end else if (take) begin
          push    = 1'b1;
          ie_d    = 1'b0;
          state_d = ST_REDIRECT;
        end else if (instr_boundary) begin
          if (ie_clr) begin
            ie_d = 1'b0;
          end else if (ie_set) begin
            ie_d = 1'b1;
          end
        end
      end
      ST_REDIRECT: begin
        redirect    = 1'b1;
        redirect_pc = vector_addr(VECTOR_BASE, VECTOR_STRIDE, top_e.id);
        state_d     = ST_SETTLE;
      end
      ST_RETURN: begin
        redirect           = 1'b1;
        redirect_pc        = ret_pc_q;
        clear_interrupt    = 1'b1;
        clear_interrupt_id = ret_id_q;
        state_d            = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
